// File: rtl/exec_pkg.sv
// exec_pkg: func/opcode codes and instruction field layout shared by the exec core
package exec_pkg;
  typedef enum logic [3:0] {
    FN_AND, FN_OR, FN_XOR, FN_NAND, FN_NOR, FN_XNOR, FN_ADD, FN_SUB,
    FN_MUL, FN_DIV, FN_MOD, FN_LT, FN_GT, FN_EQ, FN_SHL, FN_SHR
  } fn_e;
  localparam logic [2:0] OP_EXEC_WB = 3'b011;
  localparam logic [2:0] OP_EXEC    = 3'b001;
  // inst = {rd, rs1, rs2, func[3:0], opcode[2:0]}; register fields start at RS2_LSB
  localparam int FN_LSB  = 3;
  localparam int RS2_LSB = 7;
  function automatic logic is_div(input fn_e f);
    return f == FN_DIV || f == FN_MOD;
  endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring serial divider, one quotient bit per cycle, 1-cycle divide-by-zero
module seq_divider #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [DATA_W-1:0] quot_q, quot_d, rem_q, rem_d, div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, ge;
  logic [DATA_W:0] part;
  assign busy_o = cnt_q != '0;
  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  // quot_q doubles as the dividend shift register while iterating
  always_comb begin
    part   = {rem_q, quot_q[DATA_W-1]};
    ge     = part >= {1'b0, div_q};
    quot_d = quot_q;
    rem_d  = rem_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (start_i) begin
      quot_d = (b_i == '0) ? '1 : a_i;
      rem_d  = (b_i == '0) ? a_i : '0;
      div_d  = b_i;
      cnt_d  = (b_i == '0) ? '0 : CW'(DATA_W);
      done_d = b_i == '0;
    end else if (busy_o) begin
      quot_d = {quot_q[DATA_W-2:0], ge};
      rem_d  = ge ? part[DATA_W-1:0] - div_q : part[DATA_W-1:0];
      cnt_d  = cnt_q - 1'b1;
      done_d = cnt_q == CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/pipelined_exec_core.sv
// pipelined_exec_core: regfile + 2-stage ID/EX pipeline with bypass, serial divide and flags
module pipelined_exec_core
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int RA_W   = $clog2(NREGS),
  localparam int INST_W = 7 + 3 * RA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INST_W-1:0]   inst_i,
  input  logic                inst_valid_i,
  output logic                inst_ready_o,
  output logic [2*DATA_W-1:0] res_data_o,
  output logic                res_valid_o,
  output logic                res_zero_o,
  output logic                res_carry_o
);
  localparam int RW = 2 * DATA_W;
  logic [2:0] opc;
  fn_e fn, id_fn_q;
  logic [RA_W-1:0] rs1, rs2, rd, id_rd_q, rd_hi;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] op_a, op_b, id_a_q, id_b_q, ex_lo, ex_hi, quot, rem;
  logic [RW-1:0] ex_res, res_data_q;
  logic rdy_q, id_v_q, id_wb_q, res_valid_q, res_zero_q, res_carry_q;
  logic accept, live, id_fire, byp_lo, byp_hi, ex_c, div_start, div_busy, div_done;
  assign opc = inst_i[FN_LSB-1:0];
  assign fn  = fn_e'(inst_i[RS2_LSB-1:FN_LSB]);
  assign rs2 = inst_i[RS2_LSB +: RA_W];
  assign rs1 = inst_i[RS2_LSB+RA_W +: RA_W];
  assign rd  = inst_i[RS2_LSB+2*RA_W +: RA_W];
  assign live = opc == OP_EXEC_WB || opc == OP_EXEC;
  assign inst_ready_o = rdy_q && !div_busy;
  assign accept = inst_valid_i && inst_ready_o;
  assign id_fire = id_v_q && (!is_div(id_fn_q) || div_done);
  assign div_start = accept && live && is_div(fn);
  assign rd_hi = id_rd_q + 1'b1;
  // an accept implies ID retires on the same edge, so its result is safe to forward
  assign byp_lo = id_v_q && id_wb_q;
  assign byp_hi = byp_lo && id_fn_q == FN_MUL;
  always_comb begin
    op_a = regs_q[rs1];
    op_b = regs_q[rs2];
    if (byp_lo && rs1 == id_rd_q) op_a = ex_res[DATA_W-1:0];
    else if (byp_hi && rs1 == rd_hi) op_a = ex_res[RW-1:DATA_W];
    if (byp_lo && rs2 == id_rd_q) op_b = ex_res[DATA_W-1:0];
    else if (byp_hi && rs2 == rd_hi) op_b = ex_res[RW-1:DATA_W];
  end
  always_comb begin
    ex_lo = '0;
    ex_hi = '0;
    ex_c  = 1'b0;
    case (id_fn_q)
      FN_AND:  ex_lo = id_a_q & id_b_q;
      FN_OR:   ex_lo = id_a_q | id_b_q;
      FN_XOR:  ex_lo = id_a_q ^ id_b_q;
      FN_NAND: ex_lo = ~(id_a_q & id_b_q);
      FN_NOR:  ex_lo = ~(id_a_q | id_b_q);
      FN_XNOR: ex_lo = ~(id_a_q ^ id_b_q);
      FN_ADD:  {ex_c, ex_lo} = {1'b0, id_a_q} + {1'b0, id_b_q};
      FN_SUB:  {ex_c, ex_lo} = {1'b0, id_a_q} - {1'b0, id_b_q};
      FN_MUL:  {ex_hi, ex_lo} = RW'(id_a_q) * RW'(id_b_q);
      FN_DIV:  ex_lo = quot;
      FN_MOD:  ex_lo = rem;
      FN_LT:   ex_lo = DATA_W'(id_a_q < id_b_q);
      FN_GT:   ex_lo = DATA_W'(id_a_q > id_b_q);
      FN_EQ:   ex_lo = DATA_W'(id_a_q == id_b_q);
      FN_SHL:  ex_lo = id_a_q << id_b_q;
      FN_SHR:  ex_lo = id_a_q >> id_b_q;
    endcase
  end
  assign ex_res = {ex_hi, ex_lo};
  seq_divider #(.DATA_W(DATA_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .a_i     (op_a),
    .b_i     (op_b),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (quot),
    .rem_o   (rem)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      id_v_q      <= 1'b0;
      id_wb_q     <= 1'b0;
      id_fn_q     <= FN_AND;
      id_rd_q     <= '0;
      id_a_q      <= '0;
      id_b_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_W'(i);
    end else begin
      rdy_q       <= 1'b1;
      res_valid_q <= id_fire;
      if (accept) begin
        id_v_q  <= live;
        id_wb_q <= opc == OP_EXEC_WB;
        id_fn_q <= fn;
        id_rd_q <= rd;
        id_a_q  <= op_a;
        id_b_q  <= op_b;
      end else if (id_fire) begin
        id_v_q <= 1'b0;
      end
      if (id_fire) begin
        res_data_q  <= ex_res;
        res_zero_q  <= ex_res == '0;
        res_carry_q <= ex_c;
      end
      if (id_fire && id_wb_q) begin
        regs_q[id_rd_q] <= ex_lo;
        if (id_fn_q == FN_MUL) regs_q[rd_hi] <= ex_hi;
      end
    end
  end
  assign res_data_o  = res_data_q;
  assign res_valid_o = res_valid_q;
  assign res_zero_o  = res_zero_q;
  assign res_carry_o = res_carry_q;
endmodule

// File: tb/tb_pipelined_exec_core.sv
// tb_pipelined_exec_core: directed + random stimulus against an ISA-level reference model
module tb_pipelined_exec_core;
  logic clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0;
  logic [15:0] inst = '0;
  logic ready, valid, zero, carry;
  logic [15:0] res_data;
  int cyc = 0, nchk = 0, nerr = 0, waits = 0;
  typedef struct {logic [15:0] d; logic z; logic c; int due;} exp_t;
  exp_t q[$];
  logic [7:0] mreg [8];
  logic [15:0] lres = '0;
  logic lz = 1'b0, lc = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pipelined_exec_core #(.DATA_W(8), .NREGS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_i       (inst),
    .inst_valid_i (inst_valid),
    .inst_ready_o (ready),
    .res_data_o   (res_data),
    .res_valid_o  (valid),
    .res_zero_o   (zero),
    .res_carry_o  (carry)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 8'(i);
    q.delete();
  endtask
  // sequential ISA semantics: each instruction sees all earlier writes
  task automatic model(input logic [2:0] opc, input logic [3:0] fn, input int rd, input int rs1, input int rs2);
    int a, b, r, lat;
    logic c;
    exp_t e;
    a = int'(mreg[rs1]);
    b = int'(mreg[rs2]);
    c = 1'b0;
    lat = 2;
    r = 0;
    case (fn)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = ~(a & b) & 255;
      4'd4:  r = ~(a | b) & 255;
      4'd5:  r = ~(a ^ b) & 255;
      4'd6:  begin r = a + b; c = r > 255; r = r & 255; end
      4'd7:  begin c = a < b; r = (a - b) & 255; end
      4'd8:  r = a * b;
      4'd9:  begin r = (b == 0) ? 255 : a / b; lat = (b == 0) ? 2 : 10; end
      4'd10: begin r = (b == 0) ? a : a % b; lat = (b == 0) ? 2 : 10; end
      4'd11: r = int'(a < b);
      4'd12: r = int'(a > b);
      4'd13: r = int'(a == b);
      4'd14: r = (b >= 8) ? 0 : (a << b) & 255;
      4'd15: r = (b >= 8) ? 0 : a >> b;
    endcase
    if (opc == 3'b011) begin
      mreg[rd] = r[7:0];
      if (fn == 4'd8) mreg[(rd + 1) % 8] = r[15:8];
    end
    if (opc == 3'b011 || opc == 3'b001) begin
      e.d = r[15:0];
      e.z = r == 0;
      e.c = c;
      e.due = cyc + lat;
      q.push_back(e);
    end
  endtask
  task automatic send(input logic [2:0] opc, input logic [3:0] fn, input int rd, input int rs1, input int rs2);
    logic [2:0] d, s1, s2;
    d = rd[2:0];
    s1 = rs1[2:0];
    s2 = rs2[2:0];
    inst = {d, s1, s2, fn, opc};
    inst_valid = 1'b1;
    waits = 0;
    while (!ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (!ready) chk("accept_timeout", 32'(ready), 1);
    else model(opc, fn, rd, rs1, rs2);
    @(negedge clk);
    inst_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_ready", 32'(ready), 0);
    model_reset();
    rst_n = 1'b1;
    chk("ready_at_release", 32'(ready), 0);
    @(negedge clk);
    chk("ready_after_release", 32'(ready), 1);
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && valid) begin
      if (q.size() == 0) chk("spurious_valid", 32'(valid), 0);
      else begin
        e = q.pop_front();
        chk("res_data", 32'(res_data), 32'(e.d));
        chk("res_zero", 32'(zero), 32'(e.z));
        chk("res_carry", 32'(carry), 32'(e.c));
        chk("latency", cyc, e.due);
        lres = res_data;
        lz = zero;
        lc = carry;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    do_reset();
    send(3'b011, 4'd6, 3, 1, 2);
    drain();
    chk("t1_add", 32'(lres), 32'h3);
    chk("t1_zero", 32'(lz), 0);
    chk("t1_carry", 32'(lc), 0);
    send(3'b001, 4'd1, 0, 3, 3);
    drain();
    chk("t1_r3", 32'(lres), 32'h3);
    send(3'b011, 4'd6, 3, 1, 2);
    send(3'b011, 4'd6, 4, 3, 3);
    chk("t2_ready", waits, 0);
    drain();
    chk("t2_bypass", 32'(lres), 32'h6);
    send(3'b011, 4'd14, 1, 7, 5);
    send(3'b011, 4'd8, 6, 1, 1);
    drain();
    chk("t3_mul", 32'(lres), 32'hC400);
    send(3'b011, 4'd8, 7, 7, 7);
    drain();
    send(3'b001, 4'd1, 0, 0, 0);
    drain();
    chk("t3_r0_wrap", 32'(lres), 32'h96);
    send(3'b001, 4'd1, 0, 7, 7);
    drain();
    chk("t3_r7", 32'(lres), 32'h10);
    do_reset();
    send(3'b011, 4'd9, 2, 7, 3);
    send(3'b011, 4'd10, 1, 7, 3);
    chk("t4_div_hold", waits, 8);
    drain();
    chk("t4_mod", 32'(lres), 32'h1);
    send(3'b001, 4'd1, 0, 2, 2);
    drain();
    chk("t4_div", 32'(lres), 32'h2);
    send(3'b011, 4'd9, 4, 7, 0);
    send(3'b011, 4'd10, 5, 7, 0);
    chk("t4_div0_hold", waits, 0);
    drain();
    chk("t4_mod0", 32'(lres), 32'h7);
    send(3'b001, 4'd1, 0, 4, 4);
    drain();
    chk("t4_div0", 32'(lres), 32'hFF);
    do_reset();
    send(3'b011, 4'd7, 5, 0, 1);
    drain();
    chk("t5_sub", 32'(lres), 32'hFF);
    chk("t5_borrow", 32'(lc), 1);
    send(3'b011, 4'd13, 6, 2, 2);
    drain();
    chk("t5_eq", 32'(lres), 32'h1);
    chk("t5_eq_zero", 32'(lz), 0);
    send(3'b011, 4'd0, 7, 1, 2);
    drain();
    chk("t5_and_zero", 32'(lz), 1);
    send(3'b000, 4'd6, 3, 1, 2);
    repeat (4) @(negedge clk);
    send(3'b001, 4'd1, 0, 3, 3);
    drain();
    chk("t5_nop_nowrite", 32'(lres), 32'h3);
    send(3'b011, 4'd9, 2, 7, 3);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (12) @(negedge clk);
    for (int i = 0; i < 8; i++) send(3'b001, 4'd1, 0, i, i);
    send(3'b011, 4'd6, 3, 1, 2);
    drain();
    chk("t6_after_reset", 32'(lres), 32'h3);
    repeat (400) begin
      int k;
      logic [2:0] opc;
      k = $urandom_range(0, 9);
      opc = (k < 4) ? 3'b011 : (k < 7) ? 3'b001 : 3'($urandom_range(0, 7));
      send(opc, 4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
